msix_msg_tx: RTL and testbench
==============================

MSIX_MSG_TX -- requirements
Module: msix_msg_tx

Interface
REQ-001 SHALL have parameter NUM_MSIX, default 8: number of table vectors; vectors >= NUM_MSIX are invalid.
REQ-002 SHALL have parameter LOOKUP_TIMEOUT, default 16: maximum cycles to wait for tbl_rd_valid.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  single clock for all logic
- reset_n  in  1  synchronous, active-low reset
- msix_enable  in  1  MSI-X Enable from config space
- msix_function_mask  in  1  Function Mask from config space
- requester_id  in  16  bus/dev/func for the TLP header
- msix_interrupt  in  1  level request from table, held until ack
- msix_vector  in  11  vector number of the request
- msix_interrupt_ack  out  1  one-cycle pulse that retires the request
- tbl_rd_req  out  1  one-cycle table lookup strobe
- tbl_rd_vector  out  11  vector being looked up
- tbl_rd_valid  in  1  lookup result valid
- tbl_addr_lo  in  32  message address [31:0]
- tbl_addr_hi  in  32  message address [63:32]
- tbl_data  in  32  message data
- tbl_masked  in  1  per-vector mask bit
- msix_pending_set  out  1  pulse that sets the PBA bit for pend_vector
- pend_vector  out  11  vector to mark pending
- tx_valid  out  1  TLP beat valid
- tx_ready  in  1  sink accepts beat
- tx_data  out  32  TLP DW
- tx_sop  out  1  first beat of TLP
- tx_eop  out  1  last beat of TLP
- lookup_err  out  1  pulse on timeout or invalid vector

Function
REQ-004 SHALL implement FSM states IDLE, LOOKUP, WAIT, SEND, DONE.
REQ-005 IDLE SHALL accept a request when msix_interrupt=1, latch msix_vector, and move to LOOKUP, except on the first IDLE cycle after DONE, when the request is ignored (ack-to-deassert holdoff).
REQ-006 If msix_enable=0, or the latched vector is >= NUM_MSIX, IDLE SHALL go to DONE without a lookup; an invalid vector SHALL also pulse lookup_err.
REQ-007 LOOKUP SHALL assert tbl_rd_req for exactly one cycle with tbl_rd_vector equal to the latched vector, then enter WAIT.
REQ-008 In WAIT, when tbl_rd_valid=1, the block SHALL capture addr, data and mask.
- If tbl_masked or msix_function_mask (sampled the same cycle) is set: pulse msix_pending_set with pend_vector = vector, then go to DONE.
- Otherwise: go to SEND.
REQ-009 If WAIT exceeds LOOKUP_TIMEOUT cycles, the block SHALL pulse lookup_err and go to DONE without sending.
REQ-010 SEND SHALL emit a 3DW MWr when tbl_addr_hi==0 (4 beats), otherwise a 4DW MWr (5 beats).
REQ-011 The SEND beat sequence SHALL be:
- DW0: 32'h40000001 (3DW) or 32'h60000001 (4DW)
- DW1: {requester_id, tag, 4'h0, 4'hF}
- [4DW only] addr_hi
- {addr_lo[31:2], 2'b00}
- data unchanged
REQ-012 tag SHALL be an 8-bit counter, reset 0, that increments by one per completed TLP and wraps 255->0.
REQ-013 tx_sop SHALL be 1 only on DW0 and tx_eop only on the payload beat; a beat advances only when tx_valid&&tx_ready, and tx_data/sop/eop SHALL hold stable while tx_valid=1 and tx_ready=0.
REQ-014 After the eop beat is accepted, the block SHALL enter DONE.
REQ-015 DONE SHALL pulse msix_interrupt_ack for one cycle, then return to IDLE; every accepted request SHALL receive exactly one ack.
REQ-016 Latency with tx_ready=1: request sampled at cycle N, tbl_rd_req at N+1, tbl_rd_valid at N+2, DW0 at N+3, 3DW eop at N+6, ack at N+7.
REQ-017 Once in SEND, a change in msix_enable or msix_function_mask SHALL NOT abort the TLP.

Reset
REQ-018 While reset_n=0 at a clock edge, the FSM SHALL return to IDLE, and tag, the beat counter and the timeout counter SHALL clear to 0.
REQ-019 All outputs SHALL be 0 the cycle after reset, including when reset is asserted mid-TLP; a partial TLP is abandoned and no ack is issued.

Configuration
REQ-020 With macro MSIX_MSG_TX_STATS_EN defined, the block SHALL add outputs stat_sent[31:0] (TLPs completed), stat_pended[31:0] (msix_pending_set pulses) and stat_err[15:0] (lookup_err pulses). All are saturating and reset to 0.
REQ-021 Without MSIX_MSG_TX_STATS_EN, these ports and counters SHALL be absent, with no other change in behaviour.

Structure
REQ-022 Package msix_msg_tx_pkg SHALL hold: the state enum, the FMT_3DW_W/FMT_4DW_W DW0 constants, the first/last BE constants, and a function that builds the header DW.
REQ-023 The block SHALL have no sub-module; the beat mux and FSM live in msix_msg_tx.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Vector 0, addr_hi=0, addr_lo=FEE00000, data=12345678, ready=1 -> beats 40000001, {rid,00,0F}, FEE00000, 12345678; sop on beat 1, eop on beat 4, ack 1 cycle after eop.
- addr_hi=00000001, addr_lo=FEE00004 -> 5 beats, DW0=60000001, DW2=00000001, DW3=FEE00004.
- tbl_masked=1 for vector 3 -> no tx_valid; msix_pending_set pulse with pend_vector=3; one ack.
- tx_ready toggling 1010 during SEND -> no beat dropped or duplicated; data stable while stalled.
- tbl_rd_valid never asserted -> lookup_err exactly 17 cycles after entering WAIT (LOOKUP_TIMEOUT=16), followed by ack; 256 sent TLPs -> tag wraps to 00; reset_n=0 on beat 2 -> tx_valid=0 next cycle and no ack.

Source files
------------

// File: rtl/msix_msg_tx_pkg.sv
// ---------------------------------------------------------------------------
// msix_msg_tx_pkg
//   Shared types and constants for the MSI-X message transmitter.
//   - state_e       : transmitter FSM states
//   - FMT_3DW_W     : DW0 of a 3DW memory-write TLP (32-bit address, 1 DW)
//   - FMT_4DW_W     : DW0 of a 4DW memory-write TLP (64-bit address, 1 DW)
//   - FIRST_BE/LAST_BE : byte enables for a single-DW write
//   - hdr_dw1()     : builds header DW1 {requester_id, tag, last BE, first BE}
// ---------------------------------------------------------------------------
package msix_msg_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WAIT,
        SEND,
        DONE
    } state_e;

    localparam logic [31:0] FMT_3DW_W = 32'h4000_0001;
    localparam logic [31:0] FMT_4DW_W = 32'h6000_0001;

    // Single-DW write: all four bytes enabled in the first DW, no last DW.
    localparam logic [3:0] FIRST_BE = 4'hF;
    localparam logic [3:0] LAST_BE  = 4'h0;

    function automatic logic [31:0] hdr_dw1(input logic [15:0] rid,
                                            input logic [7:0]  tag);
        return {rid, tag, LAST_BE, FIRST_BE};
    endfunction

endpackage

// File: rtl/msix_msg_tx.sv
// ---------------------------------------------------------------------------
// msix_msg_tx
//   Turns an MSI-X interrupt request into a posted memory-write TLP.
//   A request (msix_interrupt + msix_vector) is looked up in the MSI-X table,
//   then either sent as a 3DW/4DW MWr, marked pending (masked vector or
//   function mask), or dropped with lookup_err (bad vector / lookup timeout).
//   Every accepted request is retired with one msix_interrupt_ack pulse.
//
//   Parameters:
//     NUM_MSIX       number of table vectors; vectors >= NUM_MSIX are invalid
//     LOOKUP_TIMEOUT max cycles spent waiting for tbl_rd_valid
//
//   Ports:
//     clk, reset_n                    clock, synchronous active-low reset
//     msix_enable, msix_function_mask config-space control bits
//     requester_id                    bus/dev/func placed in header DW1
//     msix_interrupt/msix_vector      level request, held until ack
//     msix_interrupt_ack              one-cycle retire pulse
//     tbl_rd_req/tbl_rd_vector        one-cycle table lookup strobe
//     tbl_rd_valid/tbl_addr_*/tbl_data/tbl_masked  lookup result
//     msix_pending_set/pend_vector    PBA set pulse
//     tx_valid/tx_ready/tx_data/tx_sop/tx_eop  TLP beat stream
//     lookup_err                      pulse on timeout or invalid vector
//
//   Optional build macro MSIX_MSG_TX_STATS_EN adds saturating counters
//   stat_sent, stat_pended and stat_err.
// ---------------------------------------------------------------------------
module msix_msg_tx
    import msix_msg_tx_pkg::*;
#(
    parameter int NUM_MSIX       = 8,
    parameter int LOOKUP_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        msix_enable,
    input  logic        msix_function_mask,
    input  logic [15:0] requester_id,
    input  logic        msix_interrupt,
    input  logic [10:0] msix_vector,
    output logic        msix_interrupt_ack,
    output logic        tbl_rd_req,
    output logic [10:0] tbl_rd_vector,
    input  logic        tbl_rd_valid,
    input  logic [31:0] tbl_addr_lo,
    input  logic [31:0] tbl_addr_hi,
    input  logic [31:0] tbl_data,
    input  logic        tbl_masked,
    output logic        msix_pending_set,
    output logic [10:0] pend_vector,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] tx_data,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic        lookup_err
`ifdef MSIX_MSG_TX_STATS_EN
    ,
    output logic [31:0] stat_sent,
    output logic [31:0] stat_pended,
    output logic [15:0] stat_err
`endif
);

    // -----------------------------------------------------------------------
    // State and captured request / table fields
    // -----------------------------------------------------------------------
    state_e      state_q;
    logic [10:0] vec_q;
    logic [15:0] rid_q;
    logic [31:0] addr_hi_q;
    logic [31:0] addr_lo_q;
    logic [31:0] data_q;
    logic        is4dw_q;
    logic [7:0]  tag_q;
    logic [2:0]  beat_q;
    logic [15:0] tmo_q;
    logic        holdoff_q;

    // Registered outputs
    logic        ack_q;
    logic        rd_req_q;
    logic        pend_set_q;
    logic [10:0] pend_vec_q;
    logic        tx_valid_q;
    logic [31:0] tx_data_q;
    logic        sop_q;
    logic        eop_q;
    logic        err_q;

    logic vec_invalid;
    assign vec_invalid = ({21'd0, msix_vector} >= 32'(NUM_MSIX));

    // -----------------------------------------------------------------------
    // Beat mux: content of the beat following beat_q. Slots are numbered
    // in 4DW order; a 3DW TLP simply skips slot 2 (addr_hi).
    // -----------------------------------------------------------------------
    logic [2:0]  nxt_beat_d;
    logic [2:0]  slot_d;
    logic [31:0] nxt_dw_d;
    logic        nxt_eop_d;

    always_comb begin
        nxt_beat_d = beat_q + 3'd1;
        slot_d     = (is4dw_q || (nxt_beat_d < 3'd2)) ? nxt_beat_d
                                                      : nxt_beat_d + 3'd1;
        nxt_dw_d   = '0;
        nxt_eop_d  = 1'b0;
        case (slot_d)
            3'd1: nxt_dw_d = hdr_dw1(rid_q, tag_q);
            3'd2: nxt_dw_d = addr_hi_q;
            3'd3: nxt_dw_d = {addr_lo_q[31:2], 2'b00};
            3'd4: begin
                nxt_dw_d  = data_q;
                nxt_eop_d = 1'b1;
            end
            default: nxt_dw_d = '0;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            rid_q      <= '0;
            addr_hi_q  <= '0;
            addr_lo_q  <= '0;
            data_q     <= '0;
            is4dw_q    <= 1'b0;
            tag_q      <= '0;
            beat_q     <= '0;
            tmo_q      <= '0;
            holdoff_q  <= 1'b0;
            ack_q      <= 1'b0;
            rd_req_q   <= 1'b0;
            pend_set_q <= 1'b0;
            pend_vec_q <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // Pulse outputs default low; states raise them for one cycle.
            ack_q      <= 1'b0;
            rd_req_q   <= 1'b0;
            pend_set_q <= 1'b0;
            err_q      <= 1'b0;

            case (state_q)
                IDLE: begin
                    // The requester drops its level only after seeing ack,
                    // so the first IDLE cycle after DONE still sees the
                    // retired request and must ignore it.
                    if (holdoff_q) begin
                        holdoff_q <= 1'b0;
                    end else if (msix_interrupt) begin
                        vec_q <= msix_vector;
                        if (!msix_enable || vec_invalid) begin
                            err_q   <= vec_invalid;
                            ack_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            rd_req_q <= 1'b1;
                            state_q  <= LOOKUP;
                        end
                    end
                end

                LOOKUP: begin
                    tmo_q   <= '0;
                    state_q <= WAIT;
                end

                WAIT: begin
                    if (tbl_rd_valid) begin
                        addr_hi_q <= tbl_addr_hi;
                        addr_lo_q <= tbl_addr_lo;
                        data_q    <= tbl_data;
                        rid_q     <= requester_id;
                        is4dw_q   <= (tbl_addr_hi != 32'd0);
                        if (tbl_masked || msix_function_mask) begin
                            pend_set_q <= 1'b1;
                            pend_vec_q <= vec_q;
                            ack_q      <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            beat_q     <= '0;
                            tx_valid_q <= 1'b1;
                            tx_data_q  <= (tbl_addr_hi == 32'd0) ? FMT_3DW_W
                                                                 : FMT_4DW_W;
                            sop_q      <= 1'b1;
                            eop_q      <= 1'b0;
                            state_q    <= SEND;
                        end
                    end else if (tmo_q == 16'(LOOKUP_TIMEOUT)) begin
                        err_q   <= 1'b1;
                        ack_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end

                SEND: begin
                    // tx_valid_q is always 1 here, so tx_ready alone means
                    // the current beat is accepted. Config changes are not
                    // looked at: a started TLP always completes.
                    if (tx_ready) begin
                        if (eop_q) begin
                            tx_valid_q <= 1'b0;
                            tx_data_q  <= '0;
                            sop_q      <= 1'b0;
                            eop_q      <= 1'b0;
                            beat_q     <= '0;
                            tag_q      <= tag_q + 8'd1;
                            ack_q      <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            beat_q    <= nxt_beat_d;
                            tx_data_q <= nxt_dw_d;
                            sop_q     <= 1'b0;
                            eop_q     <= nxt_eop_d;
                        end
                    end
                end

                DONE: begin
                    holdoff_q <= 1'b1;
                    state_q   <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign msix_interrupt_ack = ack_q;
    assign tbl_rd_req         = rd_req_q;
    assign tbl_rd_vector      = vec_q;
    assign msix_pending_set   = pend_set_q;
    assign pend_vector        = pend_vec_q;
    assign tx_valid           = tx_valid_q;
    assign tx_data            = tx_data_q;
    assign tx_sop             = sop_q;
    assign tx_eop             = eop_q;
    assign lookup_err         = err_q;

`ifdef MSIX_MSG_TX_STATS_EN
    // -----------------------------------------------------------------------
    // Saturating event counters
    // -----------------------------------------------------------------------
    logic        eop_acc;
    logic [31:0] sent_q;
    logic [31:0] pended_q;
    logic [15:0] errcnt_q;

    assign eop_acc = (state_q == SEND) && tx_ready && eop_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sent_q   <= '0;
            pended_q <= '0;
            errcnt_q <= '0;
        end else begin
            if (eop_acc && (sent_q != '1))
                sent_q <= sent_q + 32'd1;
            if (pend_set_q && (pended_q != '1))
                pended_q <= pended_q + 32'd1;
            if (err_q && (errcnt_q != '1))
                errcnt_q <= errcnt_q + 16'd1;
        end
    end

    assign stat_sent   = sent_q;
    assign stat_pended = pended_q;
    assign stat_err    = errcnt_q;
`endif

endmodule

// File: tb/tb_msix_msg_tx.sv
module tb_msix_msg_tx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        msix_enable;
    logic        msix_function_mask;
    logic [15:0] requester_id;
    logic        msix_interrupt;
    logic [10:0] msix_vector;
    logic        msix_interrupt_ack;
    logic        tbl_rd_req;
    logic [10:0] tbl_rd_vector;
    logic        tbl_rd_valid;
    logic [31:0] tbl_addr_lo;
    logic [31:0] tbl_addr_hi;
    logic [31:0] tbl_data;
    logic        tbl_masked;
    logic        msix_pending_set;
    logic [10:0] pend_vector;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] tx_data;
    logic        tx_sop;
    logic        tx_eop;
    logic        lookup_err;
`ifdef MSIX_MSG_TX_STATS_EN
    logic [31:0] stat_sent;
    logic [31:0] stat_pended;
    logic [15:0] stat_err;
`endif

    msix_msg_tx #(.NUM_MSIX(8), .LOOKUP_TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .msix_enable(msix_enable), .msix_function_mask(msix_function_mask),
        .requester_id(requester_id),
        .msix_interrupt(msix_interrupt), .msix_vector(msix_vector),
        .msix_interrupt_ack(msix_interrupt_ack),
        .tbl_rd_req(tbl_rd_req), .tbl_rd_vector(tbl_rd_vector),
        .tbl_rd_valid(tbl_rd_valid), .tbl_addr_lo(tbl_addr_lo),
        .tbl_addr_hi(tbl_addr_hi), .tbl_data(tbl_data), .tbl_masked(tbl_masked),
        .msix_pending_set(msix_pending_set), .pend_vector(pend_vector),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_sop(tx_sop), .tx_eop(tx_eop), .lookup_err(lookup_err)
`ifdef MSIX_MSG_TX_STATS_EN
        , .stat_sent(stat_sent), .stat_pended(stat_pended), .stat_err(stat_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    // One request: config, table response, tx_ready pattern, expected result.
    typedef struct {
        logic [10:0]      vec;
        logic             en, fmask, masked, noresp, toggle, hold;
        logic [31:0]      ahi, alo, dat;
        int               nb;
        logic [4:0][31:0] dw;
        int               npend, nerr, ack_cyc;
    } vec_t;

    function automatic vec_t mk(input logic [10:0] vec, input logic en, fmask, masked,
                                noresp, toggle, hold, input logic [31:0] ahi, alo, dat,
                                input int nb, input logic [31:0] d0, d1, d2, d3, d4,
                                input int npend, nerr, ack_cyc);
        vec_t r;
        r.vec = vec; r.en = en; r.fmask = fmask; r.masked = masked;
        r.noresp = noresp; r.toggle = toggle; r.hold = hold;
        r.ahi = ahi; r.alo = alo; r.dat = dat; r.nb = nb;
        r.dw[0] = d0; r.dw[1] = d1; r.dw[2] = d2; r.dw[3] = d3; r.dw[4] = d4;
        r.npend = npend; r.nerr = nerr; r.ack_cyc = ack_cyc;
        return r;
    endfunction

    // Iteration i samples cycle N+1+i, where N is the cycle the request is taken.
    task automatic run_req(input int id, input vec_t r);
        int          nbeats = 0, acks = 0, ack_at = -1, pends = 0, errs = 0, err_at = -1;
        int          rdreqs = 0;
        logic [10:0] pv = '0;
        logic [31:0] got [8];
        logic        resp = 1'b0, stalled = 1'b0;
        logic [31:0] p_data = '0;
        logic        p_sop = 1'b0, p_eop = 1'b0;
        string       t;
        t = $sformatf("e%0d", id);
        msix_enable = r.en; msix_function_mask = r.fmask;
        msix_vector = r.vec; msix_interrupt = 1'b1; tx_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            tbl_rd_valid = 1'b0;
            if (resp) begin
                tbl_rd_valid = 1'b1; tbl_addr_hi = r.ahi; tbl_addr_lo = r.alo;
                tbl_data = r.dat; tbl_masked = r.masked; resp = 1'b0;
            end
            if (tbl_rd_req) begin
                rdreqs++;
                chk({t, " rd_vector"}, 32'(tbl_rd_vector), 32'(r.vec));
                if (!r.noresp) resp = 1'b1;
            end
            tx_ready = r.toggle ? (i % 2 == 0) : 1'b1;
            if (stalled) begin
                chk({t, " stall_valid"}, 32'(tx_valid), 32'd1);
                chk({t, " stall_data"}, tx_data, p_data);
                chk({t, " stall_sop"}, 32'(tx_sop), 32'(p_sop));
                chk({t, " stall_eop"}, 32'(tx_eop), 32'(p_eop));
            end
            stalled = 1'b0;
            if (tx_valid) begin
                if (tx_ready) begin
                    chk($sformatf("%s sop%0d", t, nbeats), 32'(tx_sop), 32'(nbeats == 0));
                    chk($sformatf("%s eop%0d", t, nbeats), 32'(tx_eop), 32'(nbeats == r.nb - 1));
                    if (nbeats < 8) got[nbeats] = tx_data;
                    nbeats++;
                end else begin
                    stalled = 1'b1;
                end
                p_data = tx_data; p_sop = tx_sop; p_eop = tx_eop;
            end
            if (msix_pending_set) begin pends++; pv = pend_vector; end
            if (lookup_err) begin errs++; err_at = i; end
            if (msix_interrupt_ack) begin
                acks++; ack_at = i;
                if (!r.hold) msix_interrupt = 1'b0;
            end
            if (acks > 0 && i == ack_at + 2) msix_interrupt = 1'b0;
            if (acks > 0 && i >= ack_at + 5) break;
        end
        msix_interrupt = 1'b0; tbl_rd_valid = 1'b0;
        chk({t, " ack_count"}, 32'(acks), 32'd1);
        if (r.ack_cyc >= 0) chk({t, " ack_cycle"}, 32'(ack_at), 32'(r.ack_cyc));
        chk({t, " rd_reqs"}, 32'(rdreqs), 32'(r.en && r.vec < 8));
        chk({t, " nbeats"}, 32'(nbeats), 32'(r.nb));
        for (int j = 0; j < r.nb && j < nbeats; j++)
            chk($sformatf("%s dw%0d", t, j), got[j], r.dw[j]);
        chk({t, " pend_count"}, 32'(pends), 32'(r.npend));
        if (r.npend > 0) chk({t, " pend_vector"}, 32'(pv), 32'(r.vec));
        chk({t, " err_count"}, 32'(errs), 32'(r.nerr));
        if (r.nerr > 0) chk({t, " err_cycle"}, 32'(err_at), 32'(ack_at));
    endtask

    vec_t tv [11];
    vec_t w;
    logic [7:0] tag_m;
    int sent;
    int acks_r, seen;

    task automatic chk_idle_outputs(input string t);
        chk({t, " tx_valid"}, 32'(tx_valid), 32'd0);
        chk({t, " tx_data"}, tx_data, 32'd0);
        chk({t, " tx_sop"}, 32'(tx_sop), 32'd0);
        chk({t, " tx_eop"}, 32'(tx_eop), 32'd0);
        chk({t, " ack"}, 32'(msix_interrupt_ack), 32'd0);
        chk({t, " rd_req"}, 32'(tbl_rd_req), 32'd0);
        chk({t, " rd_vector"}, 32'(tbl_rd_vector), 32'd0);
        chk({t, " pend_set"}, 32'(msix_pending_set), 32'd0);
        chk({t, " pend_vector"}, 32'(pend_vector), 32'd0);
        chk({t, " lookup_err"}, 32'(lookup_err), 32'd0);
    endtask

    initial begin
        //          vec en fm mk nr tg hd  addr_hi       addr_lo       data          nb  dw0           dw1           dw2           dw3           dw4       np ne ack
        tv[0]  = mk(0, 1, 0, 0, 0, 0, 0, 32'h00000000, 32'hFEE00000, 32'h12345678, 4, 32'h40000001, 32'hABCD000F, 32'hFEE00000, 32'h12345678, 32'h0, 0, 0, 6);
        tv[1]  = mk(1, 1, 0, 0, 0, 0, 0, 32'h00000001, 32'hFEE00004, 32'hCAFEF00D, 5, 32'h60000001, 32'hABCD010F, 32'h00000001, 32'hFEE00004, 32'hCAFEF00D, 0, 0, 7);
        tv[2]  = mk(3, 1, 0, 1, 0, 0, 0, 32'h00000000, 32'hFEE00000, 32'h11111111, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 2);
        tv[3]  = mk(2, 1, 1, 0, 0, 0, 0, 32'h00000000, 32'hFEE00000, 32'h22222222, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 2);
        tv[4]  = mk(8, 1, 0, 0, 0, 0, 0, 32'h00000000, 32'hFEE00000, 32'h33333333, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1, 0);
        tv[5]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h00000000, 32'hFEE00000, 32'h44444444, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        tv[6]  = mk(7, 1, 0, 0, 0, 0, 1, 32'h00000000, 32'hFEE00007, 32'hDEADBEEF, 4, 32'h40000001, 32'hABCD020F, 32'hFEE00004, 32'hDEADBEEF, 32'h0, 0, 0, 6);
        tv[7]  = mk(5, 1, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'h0000000B, 32'h00000000, 5, 32'h60000001, 32'hABCD030F, 32'hFFFFFFFF, 32'h00000008, 32'h00000000, 0, 0, 7);
        tv[8]  = mk(4, 1, 0, 0, 0, 1, 0, 32'h00000002, 32'h80000010, 32'h0A0B0C0D, 5, 32'h60000001, 32'hABCD040F, 32'h00000002, 32'h80000010, 32'h0A0B0C0D, 0, 0, 11);
        tv[9]  = mk(6, 1, 0, 0, 0, 1, 0, 32'h00000000, 32'h1234567F, 32'h55AA55AA, 4, 32'h40000001, 32'hABCD050F, 32'h1234567C, 32'h55AA55AA, 32'h0, 0, 0, 9);
        tv[10] = mk(2, 1, 0, 0, 1, 0, 0, 32'h00000000, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1, 18);

        reset_n = 1'b0; msix_enable = 1'b0; msix_function_mask = 1'b0;
        requester_id = 16'hABCD; msix_interrupt = 1'b0; msix_vector = '0;
        tbl_rd_valid = 1'b0; tbl_addr_lo = '0; tbl_addr_hi = '0; tbl_data = '0;
        tbl_masked = 1'b0; tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < 11; k++) run_req(k, tv[k]);

        // Tag wrap: six TLPs sent so far; fill up to 256, next must use tag 00.
        sent = 6; tag_m = 8'd6;
        while (sent < 256) begin
            w = mk(1, 1, 0, 0, 0, 0, 0, 32'h0, 32'hFEE01000, 32'(sent), 4, 32'h40000001,
                   {16'hABCD, tag_m, 8'h0F}, 32'hFEE01000, 32'(sent), 32'h0, 0, 0, 6);
            run_req(100 + sent, w);
            sent++; tag_m = tag_m + 8'd1;
        end
        w = mk(3, 1, 0, 0, 0, 0, 0, 32'h0, 32'hFEE02000, 32'hA5A5A5A5, 4, 32'h40000001,
               32'hABCD000F, 32'hFEE02000, 32'hA5A5A5A5, 32'h0, 0, 0, 6);
        run_req(500, w);

        // Reset asserted while beat 2 is on the bus.
        msix_enable = 1'b1; msix_function_mask = 1'b0; msix_vector = 11'd2;
        msix_interrupt = 1'b1; tx_ready = 1'b1;
        seen = 0;
        begin
            logic resp = 1'b0;
            for (int i = 0; i < 20 && seen < 2; i++) begin
                @(posedge clk); #1;
                tbl_rd_valid = 1'b0;
                if (resp) begin
                    tbl_rd_valid = 1'b1; tbl_addr_hi = 32'h0; tbl_addr_lo = 32'hFEE00000;
                    tbl_data = 32'h0BADF00D; tbl_masked = 1'b0; resp = 1'b0;
                end
                if (tbl_rd_req) resp = 1'b1;
                if (tx_valid) seen++;
            end
        end
        chk("rst_mid reached_beat2", 32'(seen), 32'd2);
        reset_n = 1'b0; msix_interrupt = 1'b0; tbl_rd_valid = 1'b0;
        @(posedge clk); #1;
        chk_idle_outputs("rst_mid");
        reset_n = 1'b1;
        acks_r = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (msix_interrupt_ack) acks_r++;
            if (tx_valid) acks_r += 100;
        end
        chk("rst_mid no_ack_no_tx", 32'(acks_r), 32'd0);

        // Tag restarts from 0 after reset.
        w = mk(0, 1, 0, 0, 0, 0, 0, 32'h0, 32'hFEE03000, 32'h87654321, 4, 32'h40000001,
               32'hABCD000F, 32'hFEE03000, 32'h87654321, 32'h0, 0, 0, 6);
        run_req(600, w);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
